// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter: FSM states, grant encoding,
// the fixed fetch funct3 and the default watchdog limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [2:0] FUNCT3_LW           = 3'b010;
  localparam int         DEFAULT_MEM_TIMEOUT = 4096;

endpackage

// File: rtl/mem_request_arbiter.sv
// Arbitrates the core's fetch and data ports onto the single memory block, holding ce low for
// the whole access, capturing read data and guarding every access with a watchdog.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  TIMEOUT_CYCLES = DEFAULT_MEM_TIMEOUT,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_fault,
  output logic        mem_ce,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_write,
  input  logic [31:0] mem_dataout,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic        mem_fault
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state_q, state_d;
  grant_t           grant_q, grant_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  logic        ce_d, write_d;
  logic [2:0]  funct3_d;
  logic [31:0] addr_d, datain_d;
  logic        if_done_d, if_fault_d, d_done_d, d_fault_d;
  logic [31:0] if_rdata_d, d_rdata_d;

  // Completion of the current access, routed to the granted port after the case.
  logic        finish, fin_fault, fin_upd;
  logic [31:0] fin_rdata;
  grant_t      fin_port;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    wd_d       = wd_q;
    ce_d       = mem_ce;
    write_d    = mem_write;
    funct3_d   = mem_funct3;
    addr_d     = mem_addr;
    datain_d   = mem_datain;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_fault_d = if_fault;
    d_fault_d  = d_fault;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    finish     = 1'b0;
    fin_fault  = 1'b0;
    fin_upd    = 1'b0;
    fin_rdata  = '0;
    fin_port   = grant_q;

    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          grant_d  = GNT_DATA;
          funct3_d = d_funct3;
          addr_d   = d_addr;
          datain_d = d_wdata;
          write_d  = d_we;
          ce_d     = 1'b0;
          state_d  = ISSUE;
        end else if (if_req) begin
          grant_d  = GNT_FETCH;
          funct3_d = FUNCT3_LW;
          addr_d   = if_addr;
          datain_d = '0;
          write_d  = 1'b0;
          if (if_addr[1:0] != 2'b00) begin
            // Misaligned fetch never reaches memory; ce stays high.
            finish    = 1'b1;
            fin_fault = 1'b1;
            fin_upd   = 1'b1;
            fin_port  = GNT_FETCH;
          end else begin
            ce_d    = 1'b0;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        wd_d = wd_q + CNT_W'(1);
        if (mem_fault) begin
          finish    = 1'b1;
          fin_fault = 1'b1;
          fin_upd   = 1'b1;
        end else if (mem_valid) begin
          finish    = 1'b1;
          fin_rdata = mem_dataout;
          fin_upd   = 1'b1;
        end else if (!mem_busy) begin
          // Busy dropping without valid ends stores and control reads; only reads capture data.
          finish    = 1'b1;
          fin_rdata = mem_dataout;
          fin_upd   = !mem_write;
        end else if (wd_q == WD_LAST) begin
          finish    = 1'b1;
          fin_fault = 1'b1;
          fin_upd   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      ce_d    = 1'b1;
      if (fin_port == GNT_FETCH) begin
        if_done_d  = 1'b1;
        if_fault_d = fin_fault;
        if (fin_upd) if_rdata_d = fin_rdata;
      end else begin
        d_done_d  = 1'b1;
        d_fault_d = fin_fault;
        if (fin_upd) d_rdata_d = fin_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= GNT_FETCH;
      wd_q       <= '0;
      mem_ce     <= 1'b1;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_datain <= '0;
      mem_write  <= 1'b0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      if_fault   <= 1'b0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
      d_fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      grant_q    <= grant_d;
      wd_q       <= wd_d;
      mem_ce     <= ce_d;
      mem_funct3 <= funct3_d;
      mem_addr   <= addr_d;
      mem_datain <= datain_d;
      mem_write  <= write_d;
      if_rdata   <= if_rdata_d;
      if_done    <= if_done_d;
      if_fault   <= if_fault_d;
      d_rdata    <= d_rdata_d;
      d_done     <= d_done_d;
      d_fault    <= d_fault_d;
    end
  end

endmodule
